// File: rtl/sw_cfg_fifo_if.sv
// Handshake/bus bundle between the Smith-Waterman loader (master) and sw_cfg_fifo (slave).
// DATA_WIDTH and ADDR_W must match the parameters of the attached sw_cfg_fifo.
interface sw_cfg_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_W     = 7
);
  logic                  en;
  logic                  flush;
  logic [ADDR_W:0]       cfg_depth;
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic [ADDR_W:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output en, flush, cfg_depth, wr, w_data, rd,
    input  r_data, r_valid, full, almost_full, empty, count, overflow, underflow
  );

  modport slave (
    input  en, flush, cfg_depth, wr, w_data, rd,
    output r_data, r_valid, full, almost_full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sw_cfg_fifo.sv
// Synchronous FIFO with runtime-configurable depth (loaded on reset/flush) for the SW IP.
// Optional SW_FIFO_ZERO_IDLE_EN: r_data is forced to 0 in every cycle without r_valid.
module sw_cfg_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic          clk,
  input  logic          reset,
  sw_cfg_fifo_if.slave  bus
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned DEPTH_MAX = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_MAX_C = CNT_W'(DEPTH_MAX);
  localparam logic [CNT_W-1:0] AF_MARGIN_C = CNT_W'(AF_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH_MAX];

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      depth_q, depth_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;
  logic                  empty_q, empty_d;
  logic                  r_valid_q, r_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  mem_we;
  logic [CNT_W-1:0]      cfg_depth_c;

  // Pointer advance with wrap at the active depth rather than at 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p,
                                                 input logic [CNT_W-1:0]  d);
    if (CNT_W'(p) == d - CNT_W'(1)) return '0;
    return p + ADDR_W'(1);
  endfunction

  // Almost-full threshold saturates at 0 for depths not larger than the margin.
  function automatic logic af_calc(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] thr;
    thr = (d > AF_MARGIN_C) ? d - AF_MARGIN_C : '0;
    return cnt >= thr;
  endfunction

  always_comb begin
    if (bus.cfg_depth == '0 || bus.cfg_depth > DEPTH_MAX_C) cfg_depth_c = DEPTH_MAX_C;
    else                                                    cfg_depth_c = bus.cfg_depth;
  end

  // Next-state: flush wins over wr/rd; rejected ops leave pointers, count and storage alone.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    mem_we    = 1'b0;

    wr_ok = bus.en & bus.wr & ~full_q;
    rd_ok = bus.en & bus.rd & ~empty_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      depth_d  = cfg_depth_c;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
`ifdef SW_FIFO_ZERO_IDLE_EN
      r_data_d = '0;
`endif
    end else begin
      if (wr_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q, depth_q);
      end
      if (rd_ok) begin
        rd_ptr_d  = ptr_inc(rd_ptr_q, depth_q);
        r_data_d  = mem[rd_ptr_q];
        r_valid_d = 1'b1;
      end else begin
`ifdef SW_FIFO_ZERO_IDLE_EN
        r_data_d = '0;
`endif
      end
      ovf_d = ovf_q | (bus.en & bus.wr & full_q);
      unf_d = unf_q | (bus.en & bus.rd & empty_q);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == depth_d);
    af_d    = af_calc(count_d, depth_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      depth_q   <= DEPTH_MAX_C;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      empty_q   <= 1'b1;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      r_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      depth_q   <= depth_d;
      full_q    <= full_d;
      af_q      <= af_d;
      empty_q   <= empty_d;
      r_valid_q <= r_valid_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      r_data_q  <= r_data_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= bus.w_data;
  end

  assign bus.r_data      = r_data_q;
  assign bus.r_valid     = r_valid_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.empty       = empty_q;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_sw_cfg_fifo.sv
// Self-checking bench for sw_cfg_fifo: directed scenarios plus random traffic against a queue model.
// Honours SW_FIFO_ZERO_IDLE_EN the same way as the design.
module tb_sw_cfg_fifo;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sw_cfg_fifo_if #(.DATA_WIDTH(8), .ADDR_W(7)) bus ();

  sw_cfg_fifo #(.DATA_WIDTH(8), .ADDR_W(7), .AF_MARGIN(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  logic [7:0] mq [$];
  int         m_depth;
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int thr;
    thr = (m_depth > 2) ? m_depth - 2 : 0;
    chk("count",       32'(bus.count),       32'(mq.size()));
    chk("empty",       32'(bus.empty),       32'(mq.size() == 0));
    chk("full",        32'(bus.full),        32'(mq.size() == m_depth));
    chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= thr));
    chk("r_valid",     32'(bus.r_valid),     32'(m_rv));
    chk("r_data",      32'(bus.r_data),      32'(m_rdata));
    chk("overflow",    32'(bus.overflow),    32'(m_ovf));
    chk("underflow",   32'(bus.underflow),   32'(m_unf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_depth = 128;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_rv    = 1'b0;
    m_rdata = 8'h00;
  endtask

  // One clock of stimulus; the model applies the FIFO rules to the pre-edge occupancy.
  task automatic step(input bit en, input bit fl, input logic [7:0] cfg,
                      input bit wr, input logic [7:0] wd, input bit rd);
    bit was_full, was_empty;
    bus.en = en; bus.flush = fl; bus.cfg_depth = cfg;
    bus.wr = wr; bus.w_data = wd; bus.rd = rd;
    if (fl) begin
      mq.delete();
      m_depth = (cfg == 0 || cfg > 128) ? 128 : int'(cfg);
      m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0;
`ifdef SW_FIFO_ZERO_IDLE_EN
      m_rdata = 8'h00;
`endif
    end else begin
      was_full  = (mq.size() == m_depth);
      was_empty = (mq.size() == 0);
      m_rv = 1'b0;
      if (en && wr && was_full)  m_ovf = 1'b1;
      if (en && rd && was_empty) m_unf = 1'b1;
      if (en && rd && !was_empty) begin
        m_rdata = mq.pop_front();
        m_rv    = 1'b1;
      end else begin
`ifdef SW_FIFO_ZERO_IDLE_EN
        m_rdata = 8'h00;
`endif
      end
      if (en && wr && !was_full) mq.push_back(wd);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wr_word(input logic [7:0] d);   step(1, 0, 8'd0, 1, d, 0);     endtask
  task automatic rd_word();                       step(1, 0, 8'd0, 0, 8'h00, 1); endtask
  task automatic idle();                          step(1, 0, 8'd0, 0, 8'h00, 0); endtask
  task automatic do_flush(input logic [7:0] cfg); step(1, 1, cfg, 0, 8'h00, 0);  endtask

  initial begin
    logic [7:0] cfg;
    bit en, fl, wr, rd;
    int wbias, rbias;

    bus.en = 0; bus.flush = 0; bus.cfg_depth = '0;
    bus.wr = 0; bus.w_data = '0; bus.rd = 0;

    // Reset state
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;
    check_all();

    // 1: fill default depth 128, overflow, drain in order
    for (int i = 0; i < 128; i++) wr_word(8'(i));
    chk("t1_full_after_128", 32'(bus.full), 32'd1);
    chk("t1_count_128",      32'(bus.count), 32'd128);
    wr_word(8'hFF);
    chk("t1_overflow",       32'(bus.overflow), 32'd1);
    chk("t1_count_still_128", 32'(bus.count), 32'd128);
    for (int i = 0; i < 128; i++) begin
      rd_word();
      chk("t1_read_order", 32'(bus.r_data), 32'(i));
    end
    idle();
    chk("t1_empty_end", 32'(bus.empty), 32'd1);

    // 2: depth 5, almost_full at 3, full at 5, wrap-around
    do_flush(8'd5);
    wr_word(8'hA1); wr_word(8'hA2);
    chk("t2_af_at_2", 32'(bus.almost_full), 32'd0);
    wr_word(8'hA3);
    chk("t2_af_at_3", 32'(bus.almost_full), 32'd1);
    wr_word(8'hA4); wr_word(8'hA5);
    chk("t2_full_at_5", 32'(bus.full), 32'd1);
    rd_word(); rd_word();
    wr_word(8'hB1); wr_word(8'hB2);
    rd_word(); chk("t2_rd_a3", 32'(bus.r_data), 32'hA3);
    rd_word(); chk("t2_rd_a4", 32'(bus.r_data), 32'hA4);
    rd_word(); chk("t2_rd_a5", 32'(bus.r_data), 32'hA5);
    rd_word(); chk("t2_rd_b1", 32'(bus.r_data), 32'hB1);
    rd_word(); chk("t2_rd_b2", 32'(bus.r_data), 32'hB2);
    idle();

    // 3: simultaneous wr&rd mid-fill and on empty
    do_flush(8'd0);
    wr_word(8'h11); wr_word(8'h22); wr_word(8'h33);
    step(1, 0, 8'd0, 1, 8'h44, 1);
    chk("t3_count_stays_3", 32'(bus.count), 32'd3);
    rd_word(); rd_word(); rd_word();
    step(1, 0, 8'd0, 1, 8'h55, 1);
    chk("t3_empty_wrrd_count", 32'(bus.count), 32'd1);
    chk("t3_underflow",        32'(bus.underflow), 32'd1);
    chk("t3_no_rvalid",        32'(bus.r_valid), 32'd0);

    // 4: flush beats a concurrent write; cfg_depth 0 means 128
    do_flush(8'd0);
    for (int i = 0; i < 4; i++) wr_word(8'(8'hC0 + i));
    step(1, 1, 8'd0, 1, 8'hEE, 0);
    chk("t4_flush_empty", 32'(bus.empty), 32'd1);
    chk("t4_flush_count", 32'(bus.count), 32'd0);
    rd_word();
    chk("t4_read_rejected", 32'(bus.r_valid), 32'd0);
    for (int i = 0; i < 128; i++) wr_word(8'(i * 3));
    chk("t4_full_128", 32'(bus.full), 32'd1);

    // 5: asynchronous reset mid-burst
    do_flush(8'd20);
    for (int i = 0; i < 7; i++) wr_word(8'(8'h70 + i));
    rd_word();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t5_async_empty",   32'(bus.empty), 32'd1);
    chk("t5_async_count",   32'(bus.count), 32'd0);
    chk("t5_async_rvalid",  32'(bus.r_valid), 32'd0);
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 128; i++) wr_word(8'(255 - i));
    chk("t5_depth_back_128", 32'(bus.full), 32'd1);

    // 6: idle r_data behaviour after popping 0x5C
    do_flush(8'd8);
    wr_word(8'h5C);
    rd_word();
    chk("t6_pop_5c", 32'(bus.r_data), 32'h5C);
    idle(); idle();
`ifdef SW_FIFO_ZERO_IDLE_EN
    chk("t6_idle_rdata", 32'(bus.r_data), 32'h00);
`else
    chk("t6_idle_rdata", 32'(bus.r_data), 32'h5C);
`endif

    // Random traffic with phase-biased read/write rates and occasional reconfiguring flushes
    for (int i = 0; i < 4000; i++) begin
      if ((i % 200) == 0) begin
        wbias = $urandom_range(1, 9);
        rbias = 10 - wbias;
      end
      en = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) cfg = 8'($urandom_range(0, 255));
      else                           cfg = 8'($urandom_range(1, 12));
      wr = ($urandom_range(0, 9) < wbias);
      rd = ($urandom_range(0, 9) < rbias);
      step(en, fl, cfg, wr, 8'($urandom), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
